// File: rtl/div16_seq_if.sv
// Start/done handshake bundle for the sequential divider.
// The master drives the request and operands; the slave returns status and results.
interface div16_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div16_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Results and status are registered and held until the next accepted request.
module div16_seq #(
    parameter int WIDTH = 16
) (
    input logic        clk,
    input logic        rst_n,
    div16_seq_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CNT_W-1:0] cnt;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder stays below the divisor, so its top bit never feeds the next shift.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_reg[WIDTH];

    always_comb begin
        shifted  = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_reg};
        rem_next = shifted;
        q_next   = {q_reg[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial;
            q_next   = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            cnt         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        cnt    <= '0;
                        if (bus.divisor != '0) begin
                            q_reg   <= bus.dividend;
                            rem_reg <= '0;
                            dvs_reg <= bus.divisor;
                            dbz_r   <= 1'b0;
                            state   <= CALC;
                        end else begin
                            // Zero divisor skips the iterations and reports a saturated quotient.
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    q_reg   <= q_next;
                    rem_reg <= rem_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        quotient_r  <= q_next;
                        remainder_r <= rem_next[WIDTH-1:0];
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed handshake scenarios plus a
// randomized back-to-back sweep checked against plain integer division.
module tb_div16_seq;
    localparam int WIDTH  = 16;
    localparam int SWEEP  = 2000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div16_seq_if #(.WIDTH(WIDTH)) bus ();

    div16_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void refDiv(input logic [15:0] n, input logic [15:0] d,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic [31:0] dbz);
        if (d == 16'd0) begin
            q   = 32'h0000_FFFF;
            r   = {16'd0, n};
            dbz = 32'd1;
        end else begin
            q   = 32'(n / d);
            r   = 32'(n % d);
            dbz = 32'd0;
        end
    endfunction

    function automatic logic [15:0] randOperand();
        logic [15:0] v;
        int          sh;
        v  = 16'($urandom);
        sh = $urandom_range(0, 15);
        return v >> sh;
    endfunction

    // Presents one request for a single edge, then waits (bounded) for done.
    task automatic applyStimulus(input logic [15:0] n, input logic [15:0] d,
                                 output int lat, output int busyCnt);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        step();
        bus.start = 1'b0;
        lat       = 0;
        busyCnt   = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            step();
            lat++;
            if (bus.busy) busyCnt++;
        end
    endtask

    task automatic runDirected(input string tag, input logic [15:0] n, input logic [15:0] d);
        int          lat;
        int          busyCnt;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] edbz;
        refDiv(n, d, eq, er, edbz);
        applyStimulus(n, d, lat, busyCnt);
        // A zero divisor shows done in the cycle right after the accepting edge.
        checkOutput({tag, "_lat"},  32'(lat),     (d == 16'd0) ? 32'd0 : 32'd16);
        checkOutput({tag, "_busyn"}, 32'(busyCnt), (d == 16'd0) ? 32'd1 : 32'd17);
        checkOutput({tag, "_q"},    {16'd0, bus.quotient},  eq);
        checkOutput({tag, "_r"},    {16'd0, bus.remainder}, er);
        checkOutput({tag, "_dbz"},  {31'd0, bus.div_by_zero}, edbz);
        step();
        checkOutput({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, "_done_after"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int          doneCnt;
        int          doneAt;
        int          cyc;
        int          lastDone;
        int          got;
        logic        prevBusy;
        logic [15:0] nCur;
        logic [15:0] dCur;
        logic [15:0] qn[$];
        logic [15:0] qd[$];
        logic [15:0] pn;
        logic [15:0] pd;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] edbz;
        logic [31:0] prod;

        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        step();
        step();
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_q",    {16'd0, bus.quotient}, 32'd0);
        checkOutput("rst_r",    {16'd0, bus.remainder}, 32'd0);
        checkOutput("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] directed divisions");
        runDirected("d100_7",    16'd100,    16'd7);
        runDirected("dffff_1",   16'hFFFF,   16'd1);
        runDirected("dffff_ff",  16'hFFFF,   16'hFFFF);
        runDirected("d3_10",     16'd3,      16'd10);
        runDirected("d5_0",      16'd5,      16'd0);
        runDirected("d9_3",      16'd9,      16'd3);

        $display("[TB] start while busy is ignored");
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd33;
        step();
        bus.start = 1'b0;
        doneCnt   = 0;
        doneAt    = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.done) begin
                doneCnt++;
                doneAt = i;
            end
            bus.start    = (i == 5 || i == 16);
            bus.dividend = 16'd8;
            bus.divisor  = 16'd2;
        end
        bus.start = 1'b0;
        checkOutput("busyign_donecnt", 32'(doneCnt), 32'd1);
        checkOutput("busyign_doneat",  32'(doneAt),  32'd16);
        checkOutput("busyign_q", {16'd0, bus.quotient},  32'd30);
        checkOutput("busyign_r", {16'd0, bus.remainder}, 32'd10);
        checkOutput("busyign_busy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] reset mid-calculation");
        bus.start    = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor  = 16'd7;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("midrst_q",    {16'd0, bus.quotient}, 32'd0);
        checkOutput("midrst_r",    {16'd0, bus.remainder}, 32'd0);
        checkOutput("midrst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done) doneCnt++;
        end
        checkOutput("midrst_nodone", 32'(doneCnt), 32'd0);
        runDirected("d50_5", 16'd50, 16'd5);

        $display("[TB] randomized back-to-back sweep");
        nCur         = randOperand();
        dCur         = randOperand();
        if (dCur == 16'd0) dCur = 16'd1;
        bus.dividend = nCur;
        bus.divisor  = dCur;
        bus.start    = 1'b1;
        prevBusy     = bus.busy;
        cyc          = 0;
        lastDone     = -1;
        got          = 0;
        while (got < SWEEP && cyc < SWEEP * 18 + 100) begin
            step();
            cyc++;
            if (bus.busy && !prevBusy) begin
                qn.push_back(nCur);
                qd.push_back(dCur);
                nCur = randOperand();
                dCur = randOperand();
                if (dCur == 16'd0) dCur = 16'd1;
                bus.dividend = nCur;
                bus.divisor  = dCur;
            end
            if (bus.done) begin
                if (qn.size() == 0) begin
                    checkOutput("sweep_orphan_done", 32'd1, 32'd0);
                end else begin
                    pn = qn.pop_front();
                    pd = qd.pop_front();
                    refDiv(pn, pd, eq, er, edbz);
                    checkOutput("sweep_q",   {16'd0, bus.quotient},  eq);
                    checkOutput("sweep_r",   {16'd0, bus.remainder}, er);
                    checkOutput("sweep_dbz", {31'd0, bus.div_by_zero}, edbz);
                    prod = 32'(bus.quotient) * 32'(pd) + 32'(bus.remainder);
                    checkOutput("sweep_invariant",
                                {31'd0, (prod == 32'(pn)) && (bus.remainder < pd)}, 32'd1);
                end
                if (lastDone >= 0) checkOutput("sweep_spacing", 32'(cyc - lastDone), 32'd18);
                lastDone = cyc;
                got++;
            end
            prevBusy = bus.busy;
        end
        bus.start = 1'b0;
        checkOutput("sweep_count", 32'(got), 32'(SWEEP));
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
